// File: rtl/eth_pkg.sv
// Shared constants and types for the Ethernet receive path.
package eth_pkg;

  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

  localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
  localparam logic [7:0]  ETH_SFD      = 8'hD5;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    BODY,
    DROP
  } rx_state_t;

  typedef struct packed {
    logic ok;
    logic crc_err;
    logic runt;
    logic too_long;
    logic phy_err;
  } rx_status_t;

endpackage

// File: rtl/eth_crc32_step8.sv
// One-byte CRC-32 update, bits consumed LSB first (wire order).
module eth_crc32_step8
  import eth_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  logic [31:0] w_crc;

  // Eight serial shift/xor steps unrolled into one combinational update
  always_comb begin
    w_crc = i_crc;
    for (int unsigned i = 0; i < 8; i++) begin
      w_crc = {w_crc[30:0], 1'b0} ^ ((w_crc[31] ^ i_data[i]) ? CRC_POLY : '0);
    end
  end

  assign o_crc = w_crc;

endmodule

// File: rtl/eth_rx_frame.sv
// Receive framer: preamble/SFD hunt, FCS stripping, CRC and length status.
module eth_rx_frame
  import eth_pkg::*;
#(
  parameter int unsigned MIN_FRAME = 64,
  parameter int unsigned MAX_FRAME = 1518
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_en,
  input  logic       rx_dv,
  input  logic       rx_er,
  input  logic [7:0] rx_data,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_sof,
  output logic       out_eof,
  output logic       frame_done,
  output logic       frame_ok,
  output logic       crc_err,
  output logic       runt,
  output logic       too_long,
  output logic       phy_err
);

  rx_state_t  r_state;
  logic [31:0] r_crc;
  logic [10:0] r_cnt;
  logic        r_phy;
  logic [7:0]  r_dly [4];
  logic [7:0]  r_pend;
  rx_status_t  r_status;

  logic [31:0] w_crc_next;
  rx_status_t  w_status;

  eth_crc32_step8 u_crc (
    .i_crc  (r_crc),
    .i_data (rx_data),
    .o_crc  (w_crc_next)
  );

  // Status of the frame being closed by the current rx_dv=0 beat
  always_comb begin
    w_status          = '0;
    w_status.runt     = 32'(r_cnt) < MIN_FRAME;
    w_status.too_long = 32'(r_cnt) > MAX_FRAME;
    w_status.crc_err  = (r_crc != CRC_RESIDUE);
    w_status.phy_err  = r_phy | rx_er;
    w_status.ok       = !(w_status.runt | w_status.too_long |
                          w_status.crc_err | w_status.phy_err);
  end

  // Framing state machine, delay line and registered outputs.
  // The byte count doubles as the fill level of the delay line: with
  // count>=4 the line is full, with count>=5 the pending byte is valid,
  // and the pending byte is always body byte count-5.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_crc      <= CRC_INIT;
      r_cnt      <= '0;
      r_phy      <= 1'b0;
      r_pend     <= '0;
      for (int unsigned i = 0; i < 4; i++) r_dly[i] <= '0;
      r_status   <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sof    <= 1'b0;
      out_eof    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      out_eof    <= 1'b0;
      frame_done <= 1'b0;
      if (rx_en) begin
        case (r_state)
          IDLE: begin
            if (rx_dv) r_state <= (rx_data == ETH_PREAMBLE) ? PREAMBLE : DROP;
          end
          PREAMBLE: begin
            if (!rx_dv) begin
              r_state <= IDLE;
            end else if (rx_data == ETH_SFD) begin
              r_state <= BODY;
              r_crc   <= CRC_INIT;
              r_cnt   <= '0;
              r_phy   <= 1'b0;
            end else if (rx_data != ETH_PREAMBLE) begin
              r_state <= DROP;
            end
          end
          BODY: begin
            if (rx_dv) begin
              r_crc <= w_crc_next;
              r_phy <= r_phy | rx_er;
              if (r_cnt != '1) r_cnt <= r_cnt + 11'd1;
              if (r_cnt >= 11'd5) begin
                out_valid <= 1'b1;
                out_data  <= r_pend;
                out_sof   <= (r_cnt == 11'd5);
              end
              if (r_cnt >= 11'd4) r_pend <= r_dly[3];
              r_dly[0] <= rx_data;
              for (int unsigned i = 1; i < 4; i++) r_dly[i] <= r_dly[i-1];
            end else begin
              r_state    <= IDLE;
              frame_done <= 1'b1;
              r_status   <= w_status;
              if (r_cnt >= 11'd5) begin
                out_valid <= 1'b1;
                out_data  <= r_pend;
                out_sof   <= (r_cnt == 11'd5);
                out_eof   <= 1'b1;
              end
            end
          end
          DROP: begin
            if (!rx_dv) r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign frame_ok = r_status.ok;
  assign crc_err  = r_status.crc_err;
  assign runt     = r_status.runt;
  assign too_long = r_status.too_long;
  assign phy_err  = r_status.phy_err;

endmodule

// File: tb/tb_eth_rx_frame.sv
// Self-checking bench for eth_rx_frame: table of frame cases plus
// hand-written DROP and mid-frame reset sequences.
module tb_eth_rx_frame;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_en;
  logic       rx_dv;
  logic       rx_er;
  logic [7:0] rx_data;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_sof;
  logic       out_eof;
  logic       frame_done;
  logic       frame_ok;
  logic       crc_err;
  logic       runt;
  logic       too_long;
  logic       phy_err;

  eth_rx_frame #(.MIN_FRAME(64), .MAX_FRAME(1518)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_en      (rx_en),
    .rx_dv      (rx_dv),
    .rx_er      (rx_er),
    .rx_data    (rx_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_sof    (out_sof),
    .out_eof    (out_eof),
    .frame_done (frame_done),
    .frame_ok   (frame_ok),
    .crc_err    (crc_err),
    .runt       (runt),
    .too_long   (too_long),
    .phy_err    (phy_err)
  );

  always #5 clk = ~clk;

  // exp_st = {ok, crc_err, runt, too_long, phy_err}
  typedef struct {
    int         len;
    logic [7:0] base;
    int         flip;
    int         er_at;
    bit         paced;
    bit         fixed_fcs;
    logic [4:0] exp_st;
  } vec_t;

  vec_t       vecs[10];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [9:0] rxq[$];
  int         done_cnt  = 0;
  logic [4:0] st        = '0;
  logic       prev_beat = 1'b0;
  int         bad_pace  = 0;

  // Remember whether the edge that produced this cycle's outputs was a beat
  always @(posedge clk) prev_beat <= rx_en;

  // Output monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (out_valid) begin
      rxq.push_back({out_sof, out_eof, out_data});
      if (!prev_beat) bad_pace++;
    end
    if (frame_done) begin
      done_cnt++;
      st = {frame_ok, crc_err, runt, too_long, phy_err};
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got time limit, required $finish earlier");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic en, input logic dv, input logic er, input logic [7:0] d);
    @(posedge clk);
    #1;
    rx_en = en; rx_dv = dv; rx_er = er; rx_data = d;
  endtask

  // One beat, optionally followed by two non-beat cycles carrying junk
  task automatic beat(input logic dv, input logic er, input logic [7:0] d, input bit paced);
    drive(1'b1, dv, er, d);
    if (paced) begin
      drive(1'b0, 1'b1, 1'b1, 8'h00);
      drive(1'b0, 1'b1, 1'b1, 8'h00);
    end
  endtask

  task automatic wait_done(input int d0, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done_cnt != d0) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_case(input int idx);
    vec_t       v;
    logic [7:0] fr[$];
    logic [31:0] r;
    logic [31:0] fcs;
    int         d0;
    bit         seen;
    int         bad_d;
    int         bad_m;
    string      fn[5];
    fn = '{"ok", "crc_err", "runt", "too_long", "phy_err"};
    v = vecs[idx];
    for (int i = 0; i < v.len; i++) fr.push_back(v.base + 8'(i));
    // Reference CRC-32 in the reflected (shift-right) form
    r = '1;
    foreach (fr[i]) begin
      r = r ^ {24'h0, fr[i]};
      for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    fcs = v.fixed_fcs ? 32'hCBF43926 : ~r;
    for (int i = 0; i < 4; i++) fr.push_back(fcs[8*i +: 8]);
    if (v.flip >= 0) fr[v.flip] = fr[v.flip] ^ 8'h01;

    rxq.delete();
    d0 = done_cnt;
    for (int i = 0; i < 7; i++) beat(1'b1, 1'b0, 8'h55, v.paced);
    beat(1'b1, 1'b0, 8'hD5, v.paced);
    foreach (fr[i]) beat(1'b1, (i == v.er_at), fr[i], v.paced);
    beat(1'b0, 1'b0, 8'h00, v.paced);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    wait_done(d0, seen);

    chk($sformatf("v%0d_done", idx), 32'(seen), 32'd1);
    chk($sformatf("v%0d_len", idx), rxq.size(), v.len);
    bad_d = 0;
    bad_m = 0;
    foreach (rxq[j]) begin
      if (j < v.len && rxq[j][7:0] !== fr[j]) bad_d++;
      if (rxq[j][9] !== (j == 0) || rxq[j][8] !== (j == v.len - 1)) bad_m++;
    end
    chk($sformatf("v%0d_payload_bad_bytes", idx), bad_d, 0);
    chk($sformatf("v%0d_sof_eof_bad", idx), bad_m, 0);
    for (int k = 0; k < 5; k++)
      chk($sformatf("v%0d_%s", idx, fn[k]), 32'(st[4-k]), 32'(v.exp_st[4-k]));
    repeat (4) drive(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    int  d0;
    bit  seen;
    vecs[0] = '{60,   8'h00, -1, -1, 1'b0, 1'b0, 5'b10000}; // good 64-byte frame
    vecs[1] = '{9,    8'h31, -1, -1, 1'b0, 1'b1, 5'b00100}; // "123456789", runt
    vecs[2] = '{60,   8'h00, 20, -1, 1'b0, 1'b0, 5'b01000}; // corrupted byte
    vecs[3] = '{60,   8'h00, -1, -1, 1'b1, 1'b0, 5'b10000}; // paced 1,0,0
    vecs[4] = '{1515, 8'h00, -1, -1, 1'b0, 1'b0, 5'b00010}; // 1519-byte body
    vecs[5] = '{60,   8'h00, -1, 10, 1'b0, 1'b0, 5'b00001}; // rx_er mid-body
    vecs[6] = '{0,    8'h00, -1, -1, 1'b0, 1'b0, 5'b00100}; // FCS only
    vecs[7] = '{1,    8'h7E, -1, -1, 1'b0, 1'b0, 5'b00100}; // single payload byte
    vecs[8] = '{1514, 8'h10, -1, -1, 1'b0, 1'b0, 5'b10000}; // exactly MAX_FRAME
    vecs[9] = '{59,   8'h00, -1, -1, 1'b0, 1'b0, 5'b00100}; // MIN_FRAME-1

    reset = 1'b1; rx_en = 1'b0; rx_dv = 1'b0; rx_er = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 32'({out_valid, out_data, out_sof, out_eof, frame_done,
                              frame_ok, crc_err, runt, too_long, phy_err}), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 10; i++) run_case(i);

    // Bad preamble byte: whole frame dropped silently
    rxq.delete();
    d0 = done_cnt;
    beat(1'b1, 1'b0, 8'h55, 1'b0);
    beat(1'b1, 1'b0, 8'h55, 1'b0);
    beat(1'b1, 1'b0, 8'hAA, 1'b0);
    for (int i = 0; i < 20; i++) beat(1'b1, 1'b0, 8'(i), 1'b0);
    beat(1'b0, 1'b0, 8'h00, 1'b0);
    repeat (10) drive(1'b0, 1'b0, 1'b0, 8'h00);
    chk("drop_out_valid_count", rxq.size(), 0);
    chk("drop_frame_done_count", done_cnt - d0, 0);
    run_case(0);

    // Reset in the middle of a body after 30 bytes
    beat(1'b1, 1'b0, 8'h55, 1'b0);
    beat(1'b1, 1'b0, 8'hD5, 1'b0);
    for (int i = 0; i < 30; i++) beat(1'b1, 1'b0, 8'(i), 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1; rx_en = 1'b0; rx_dv = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midreset_outputs", 32'({out_valid, out_data, out_sof, out_eof, frame_done,
                                 frame_ok, crc_err, runt, too_long, phy_err}), 32'd0);
    rxq.delete();
    d0 = done_cnt;
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b0, 8'h00);
    wait_done(d0, seen);
    chk("midreset_frame_done_seen", 32'(seen), 32'd0);
    chk("midreset_out_after_reset", rxq.size(), 0);
    run_case(0);

    chk("out_valid_without_beat", bad_pace, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/eth_rx_frame.md
Name: eth_rx_frame

Overview:
- Receive-side Ethernet framer: the counterpart of the transmit FCS generator.
- Takes a byte-wide MII/GMII-style stream, hunts for preamble and SFD, and strips the 4-byte FCS.
- Forwards the payload bytes (DA through end of data) downstream with sof/eof markers.
- Checks CRC-32 over the body and issues a one-cycle frame status pulse.
- Sits between the PHY interface adapter and the packet parser.

Parameters:
- MIN_FRAME, 64, minimum body length in bytes, FCS included; shorter frames are runts.
- MAX_FRAME, 1518, maximum body length in bytes, FCS included; longer frames are too_long.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- rx_en  in  1  byte strobe; rx_dv, rx_er and rx_data are sampled only when rx_en=1
- rx_dv  in  1  receive data valid
- rx_er  in  1  receive error from PHY
- rx_data  in  8  receive byte; bit 0 is first on the wire
- out_valid  out  1  out_data holds a payload byte this cycle
- out_data  out  8  payload byte
- out_sof  out  1  first payload byte of the frame, qualified by out_valid
- out_eof  out  1  last payload byte of the frame, qualified by out_valid
- frame_done  out  1  one-cycle status strobe
- frame_ok  out  1  frame good, valid with frame_done
- crc_err  out  1  valid with frame_done
- runt  out  1  valid with frame_done
- too_long  out  1  valid with frame_done
- phy_err  out  1  valid with frame_done

Behaviour:
- Clock is clk. Reset is reset: synchronous, active-high.
- Reset values:
  - State is IDLE.
  - All outputs are 0.
  - The CRC register is 32'hFFFFFFFF.
  - The byte counter is 0 and the delay line is empty.
  - Reset mid-frame aborts that frame silently: no frame_done and no eof.
- A "beat" is a cycle with rx_en=1. Nothing advances in a cycle with rx_en=0.
- State machine:
  - IDLE: a beat with rx_dv=1 and rx_data=0x55 goes to PREAMBLE. A beat with rx_dv=1 and any other byte goes to DROP.
  - PREAMBLE: 0x55 stays in PREAMBLE; 0xD5 goes to BODY; any other byte goes to DROP; rx_dv=0 goes to IDLE silently.
  - BODY: each beat with rx_dv=1 accepts one byte. A beat with rx_dv=0 ends the frame and goes to IDLE.
  - DROP: waits for a beat with rx_dv=0, then goes to IDLE. It emits no output and no frame_done.
- Entering BODY loads CRC=all-ones, count=0, and clears the sticky phy_err flag.
- CRC update, per accepted byte:
  - Eight iterations, LSB first.
  - Each iteration: do_xor = crc[31] ^ bit; crc = {crc[30:0],0} ^ (do_xor ? 32'h04C11DB7 : 0).
  - FCS bytes are fed through the same update.
- Frame is CRC-good iff crc == 32'hC704DD7B after the last accepted byte.
- Counter: 11-bit byte count, saturating at 2047.
- FCS stripping:
  - The delay line is 4 bytes, followed by a 1-byte pending register.
  - Body byte k goes to pending when byte k+4 is accepted.
  - Pending byte k is emitted (out_valid=1, registered, the cycle after the edge that accepts byte k+5) when byte k+5 is accepted.
  - out_sof=1 on the emission of byte 0.
- End of frame (rx_dv=0 beat in BODY):
  - If pending is full, it is emitted in the next cycle with out_eof=1. frame_done is asserted in that same cycle.
  - If the body is shorter than 5 bytes, nothing is emitted and frame_done is still pulsed.
  - If byte 0 is the last payload byte, it carries both sof and eof.
- Status, valid with frame_done:
  - runt = count < MIN_FRAME.
  - too_long = count > MAX_FRAME.
  - crc_err = (crc != residue).
  - phy_err = a sticky OR of rx_er over BODY beats.
  - frame_ok = !(runt | too_long | crc_err | phy_err).
- Too-long frames are still forwarded; only the status flags them.
- Status outputs hold their last values until the next frame_done.
- out_valid, out_sof, out_eof and frame_done are single-cycle pulses, low otherwise.
- There is no backpressure; the consumer must accept every out_valid.

Decomposition:
- Package eth_pkg holds:
  - CRC_POLY = 32'h04C11DB7, CRC_INIT = 32'hFFFFFFFF, CRC_RESIDUE = 32'hC704DD7B
  - ETH_PREAMBLE = 8'h55, ETH_SFD = 8'hD5
  - enum rx_state_t {IDLE, PREAMBLE, BODY, DROP}
  - struct rx_status_t {ok, crc_err, runt, too_long, phy_err}
- Sub-module eth_crc32_step8: combinational byte update, 32-bit crc in, 8-bit data in, 32-bit crc out, LSB-first.

Test Plan:
1. Preamble 7x55, D5, then 60 bytes 0x00..0x3B, then FCS from the bench model; rx_en=1 every cycle.
   - Expect 60 out bytes 0x00..0x3B, sof on 0x00, eof on 0x3B.
   - Expect frame_done with frame_ok=1 and all error flags 0.
2. Preamble, D5, "123456789" (0x31..0x39), then 26 39 F4 CB.
   - Expect 9 bytes out, eof on 0x39.
   - Expect crc_err=0, runt=1, frame_ok=0.
3. Test 1 with payload byte 20 bit-flipped.
   - Expect all 60 bytes emitted, crc_err=1, frame_ok=0.
4. Test 1 with rx_en toggling 1,0,0,1 (GMII at 10/100 pacing).
   - Expect identical out byte sequence and status; no output on non-beat cycles.
5. Preamble 55 55 then 0xAA, frame continues.
   - Expect DROP: no out_valid, no frame_done.
   - Expect a following good frame to be received normally.
6. Reset asserted mid-BODY after 30 bytes.
   - Expect outputs 0 next cycle and no frame_done.
   - Expect the next good frame to give frame_ok=1.
7. Additional: 1519-byte body with valid FCS.
   - Expect too_long=1, frame_ok=0, crc_err=0.
8. Additional: rx_er pulse during BODY.
   - Expect phy_err=1, frame_ok=0.
